prog_loader: RTL
================

Name: prog_loader

Overview:
- Sequences the UART receive path while program-receive mode is active.
- Consumes bytes from the UART mux (rx_data/rx_full/rd) and assembles little-endian 16-bit words.
- Writes the words sequentially into instruction memory and holds the CPU in reset for the whole load.
- Sits between the UART mux, the instruction memory write port and the CPU reset input. Releases the CPU when the terminator word arrives.

Parameters:
- ADDR_WIDTH, 10, instruction memory word-address width; capacity 2**ADDR_WIDTH words.
- START_ADDR, 0, first word address written on each load.
- TERM_WORD, 16'hFF7F, terminator word (bytes 0x7F then 0xFF); never written to memory.

Ports:
- rst  in  1  asynchronous reset, active-high
- clk  in  1  clock
- prog_recv  in  1  program-receive mode flag from the UART mux
- rx_data  in  8  received byte; valid while rx_full=1
- rx_full  in  1  received byte available
- rd  out  1  consume current byte; combinational
- tx_data  out  8  byte to transmit (optional feature)
- wr  out  1  transmit strobe, one cycle (optional feature)
- tx_ready  in  1  UART transmitter ready
- mem_addr  out  ADDR_WIDTH  instruction memory write address
- mem_wdata  out  16  instruction memory write data
- mem_we  out  1  instruction memory write enable, one cycle per word
- cpu_rst  out  1  CPU reset request
- load_done  out  1  one-cycle pulse at end of load
- overflow  out  1  sticky; a word arrived beyond capacity
- word_count  out  ADDR_WIDTH+1  words written in the current/last load

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock. While rst is asserted:
  - state=IDLE; mem_addr=START_ADDR.
  - mem_wdata, word_count, tx_data, checksum = 0.
  - mem_we, wr, load_done, overflow, cpu_rst = 0.
  - rd = 0, since rd is combinational from state.
- Reset asserted in any state aborts the load immediately. Partial memory contents are left as written.
- States: IDLE, LO, HI, WRITE, SEND, DONE.
- IDLE:
  - A rising edge of prog_recv (registered previous value 0, current 1) moves to LO.
  - Same edge: cpu_rst<=1, mem_addr<=START_ADDR, word_count<=0, overflow<=0, checksum<=0.
  - In IDLE, rd=0; bytes are left in the mux.
- LO: rd = rx_full. On a cycle with rx_full=1, latch rx_data into the low byte and go to HI.
- HI:
  - rd = rx_full. On a cycle with rx_full=1, form word {rx_data, low byte}.
  - If the word == TERM_WORD: go to SEND if PROG_ECHO_EN is defined, else DONE.
  - Otherwise: mem_wdata<=word, checksum += both bytes (mod 256), go to WRITE.
- WRITE (one cycle):
  - If word_count < 2**ADDR_WIDTH: mem_we=1 with mem_addr/mem_wdata stable, then mem_addr+1 and word_count+1.
  - Else: mem_we=0 and overflow<=1 (sticky until next load start).
  - Always returns to LO.
  - mem_we is asserted exactly one cycle after the high byte is consumed.
- mem_addr wraps modulo 2**ADDR_WIDTH. No write is issued after capacity is reached, so wrapping never overwrites.
- SEND: wait for tx_ready=1; that cycle wr=1, tx_data=checksum; next state DONE.
- DONE (one cycle): load_done=1, cpu_rst<=0, go to IDLE.
- prog_recv falling does not end a load; only TERM_WORD ends it. The mux delivers 0x7F/0xFF after clearing prog_recv.
- A prog_recv rising edge while not in IDLE is ignored.
- rd is never asserted when rx_full=0. At most one byte is consumed per cycle.
- Only one byte per two-cycle window is possible, because the mux refills rx_full no sooner than the next cycle.

Optional Feature:
- Macro: PROG_ECHO_EN.
- Defined: the SEND state exists. After the terminator, the 8-bit sum of all written data bytes is transmitted once via wr/tx_data, with a tx_ready handshake, before DONE.
- Undefined: the SEND state and checksum register are omitted; wr is tied 0, tx_data is tied 0; HI goes directly to DONE on the terminator.

Test Plan:
- Basic load:
  - Stimulus: prog_recv 0->1, then bytes 34 12 78 56 7F FF.
  - Required: mem_we at addr 0 data 0x1234, then addr 1 data 0x5678.
  - Required: word_count=2, load_done pulses once, cpu_rst high from the cycle after the edge until DONE.
- Termination after mode drop: prog_recv drops before the 0x7F byte. Required: the load still completes on FF7F and no write of 0xFF7F occurs.
- Handshake pacing:
  - Stimulus: bytes arriving with 0-20 idle cycles between them.
  - Required: rd asserted only when rx_full=1, exactly once per byte; mem_we exactly one cycle after the high byte.
- Overflow:
  - Stimulus: ADDR_WIDTH=2, send 5 data words + terminator.
  - Required: writes only to addrs 0-3, overflow=1, word_count=4, load completes.
- Reset mid-load: assert rst while in HI. Required: all outputs go to reset values immediately, including cpu_rst=0 and mem_we=0; state is IDLE.
- PROG_ECHO_EN:
  - Stimulus: words 0x1234 and 0x5678, with tx_ready held 0 for 10 cycles.
  - Required: wr is pulsed once after tx_ready rises, with tx_data=0x14 (0x34+0x12+0x78+0x56 mod 256); then load_done.

Source files
------------

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Program loader that sits between the UART receive mux, the instruction
// memory write port and the CPU reset input. When program-receive mode starts
// (rising edge of prog_recv), the CPU is held in reset. Incoming bytes are
// paired into little-endian 16-bit words and written to consecutive
// instruction memory addresses starting at START_ADDR. The terminator word
// TERM_WORD ends the load. It is never written to memory, and the CPU is
// released one cycle later.
//
// Optional build macro: PROG_ECHO_EN
//   When defined, the 8-bit sum of all data bytes is sent once to the UART
//   transmitter (tx_ready handshake) after the terminator, before the load
//   completes. When undefined, wr and tx_data are tied low.
//
// Ports:
//   rst        in   async reset, active-high
//   clk        in   clock
//   prog_recv  in   program-receive mode flag from the UART mux
//   rx_data    in   received byte, valid while rx_full=1
//   rx_full    in   received byte available
//   rd         out  consume current byte (combinational)
//   tx_data    out  byte to transmit (echo feature)
//   wr         out  one-cycle transmit strobe (echo feature)
//   tx_ready   in   UART transmitter ready
//   mem_addr   out  instruction memory write address
//   mem_wdata  out  instruction memory write data
//   mem_we     out  instruction memory write enable, one cycle per word
//   cpu_rst    out  CPU reset request, high for the whole load
//   load_done  out  one-cycle pulse at end of load
//   overflow   out  sticky, a word arrived beyond memory capacity
//   word_count out  words written in the current/last load
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
  parameter logic [15:0]           TERM_WORD  = 16'hFF7F
) (
  input  logic                  rst,
  input  logic                  clk,
  input  logic                  prog_recv,
  input  logic [7:0]            rx_data,
  input  logic                  rx_full,
  output logic                  rd,
  output logic [7:0]            tx_data,
  output logic                  wr,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  mem_we,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   word_count
);

  // Memory capacity in words; word_count is one bit wider so it can reach it.
  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LO    = 3'd1,
    HI    = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
`ifdef PROG_ECHO_EN
    ,
    SEND  = 3'd5
`endif
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        prog_prev;
  logic        prog_rise;
  logic [7:0]  low_byte;
  logic [15:0] word;
  logic        has_room;

  assign prog_rise = prog_recv & ~prog_prev;
  assign word      = {rx_data, low_byte};
  assign has_room  = (word_count < CAPACITY);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and byte-consume strobe.
  always_comb begin
    next_state = state;
    rd         = 1'b0;
    case (state)
      IDLE: begin
        if (prog_rise) begin
          next_state = LO;
        end else begin
          next_state = IDLE;
        end
      end
      LO: begin
        rd = rx_full;
        if (rx_full) begin
          next_state = HI;
        end else begin
          next_state = LO;
        end
      end
      HI: begin
        rd = rx_full;
        if (rx_full) begin
          if (word == TERM_WORD) begin
`ifdef PROG_ECHO_EN
            next_state = SEND;
`else
            next_state = DONE;
`endif
          end else begin
            next_state = WRITE;
          end
        end else begin
          next_state = HI;
        end
      end
      WRITE: begin
        next_state = LO;
      end
`ifdef PROG_ECHO_EN
      SEND: begin
        if (tx_ready) begin
          next_state = DONE;
        end else begin
          next_state = SEND;
        end
      end
`endif
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Load datapath: address/count, write data, strobes and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prog_prev  <= 1'b0;
      low_byte   <= 8'd0;
      mem_addr   <= START_ADDR;
      mem_wdata  <= 16'd0;
      mem_we     <= 1'b0;
      cpu_rst    <= 1'b0;
      load_done  <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      prog_prev <= prog_recv;
      // Write enable lines up with the WRITE cycle, when address/data are
      // stable; suppressed once the memory is full.
      mem_we    <= (state == HI) && (next_state == WRITE) && has_room;
      load_done <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (prog_rise) begin
            cpu_rst    <= 1'b1;
            mem_addr   <= START_ADDR;
            word_count <= '0;
            overflow   <= 1'b0;
          end
        end
        LO: begin
          if (rx_full) begin
            low_byte <= rx_data;
          end
        end
        HI: begin
          if (rx_full && (word != TERM_WORD)) begin
            mem_wdata <= word;
          end
        end
        WRITE: begin
          // Once full, the address stays put, so wrapping can never
          // overwrite earlier words.
          if (has_room) begin
            mem_addr   <= mem_addr + ADDR_WIDTH'(1);
            word_count <= word_count + (ADDR_WIDTH + 1)'(1);
          end else begin
            overflow <= 1'b1;
          end
        end
        DONE: begin
          cpu_rst <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef PROG_ECHO_EN
  logic [7:0] checksum;

  // 8-bit running sum of both bytes of a data word.
  function automatic logic [7:0] add_word_bytes(input logic [7:0] acc,
                                                input logic [15:0] w);
    return acc + w[7:0] + w[15:8];
  endfunction

  // Checksum accumulation and echo byte capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= 8'd0;
      tx_data  <= 8'd0;
    end else begin
      if ((state == IDLE) && prog_rise) begin
        checksum <= 8'd0;
      end else if ((state == HI) && (next_state == WRITE)) begin
        checksum <= add_word_bytes(checksum, word);
      end else if ((state == HI) && (next_state == SEND)) begin
        tx_data <= checksum;
      end
    end
  end

  assign wr = (state == SEND) & tx_ready;
`else
  logic unused_tx_ready;

  assign unused_tx_ready = tx_ready;
  assign wr              = 1'b0;
  assign tx_data         = 8'd0;
`endif

endmodule
